// File: rtl/uart_alu_frame_ctl_if.sv
// Handshake bundle between the frame sequencer and its UART receiver/transmitter and ALU.
// master: the sequencer; slave: the UART/ALU side.
interface uart_alu_frame_ctl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              rx_d_val;
    logic [7:0]        rx_data;
    logic              tx_d_end;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [DATA_W-1:0] alu_data_a;
    logic [DATA_W-1:0] alu_data_b;
    logic [2:0]        alu_cs;
    logic              alu_cin;
    logic              alu_start;
    logic              alu_done;
    logic [DATA_W-1:0] alu_res;
    logic [7:0]        alu_flags;
    logic              en_rx;
    logic              busy;
    logic              err_timeout;

    modport master (
        input  rx_d_val, rx_data, tx_d_end, alu_done, alu_res, alu_flags,
        output tx_start, tx_data, alu_data_a, alu_data_b, alu_cs, alu_cin, alu_start,
               en_rx, busy, err_timeout
    );

    modport slave (
        output rx_d_val, rx_data, tx_d_end, alu_done, alu_res, alu_flags,
        input  tx_start, tx_data, alu_data_a, alu_data_b, alu_cs, alu_cin, alu_start,
               en_rx, busy, err_timeout
    );
endinterface

// File: rtl/uart_alu_frame_ctl.sv
// UART-to-ALU sequencer: collects an A/B/opcode frame, starts the ALU, then returns the
// result bytes (LSB first) followed by the flags byte through the transmitter.
module uart_alu_frame_ctl #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input logic                  clk,
    input logic                  rst_n,
    uart_alu_frame_ctl_if.master bus_io
);
    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TxW  = $clog2(NB + 2);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 2);

    localparam logic [CntW-1:0] LastByte = CntW'(NB - 1);
    localparam logic [TxW-1:0]  LastTx   = TxW'(NB);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StRxA, StRxB, StRxOp, StStart, StAluWait, StTxByte, StTxWait
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [TxW-1:0]    txcnt_q;
    logic [TmoW-1:0]   tmo_q;
    logic [DATA_W-1:0] a_q, b_q, shreg_q;
    logic [2:0]        cs_q;
    logic              cin_q, alu_start_q, tx_start_q, en_rx_q, err_q;
    logic [7:0]        tx_data_q;

    logic              rx_phase, frame_open, tmo_hit, rx_acc;
    logic [DATA_W-1:0] slot_d;
    logic [DATA_W+7:0] cap;

    always_comb begin
        rx_phase   = (state_q == StRxA) || (state_q == StRxB) || (state_q == StRxOp);
        frame_open = rx_phase && !((state_q == StRxA) && (cnt_q == '0));
        tmo_hit    = (TIMEOUT_CYC != 0) && frame_open && (tmo_q == TmoLast);
        // Expiry wins over a byte arriving in the same cycle.
        rx_acc     = rx_phase && bus_io.rx_d_val && !tmo_hit;
        slot_d     = (state_q == StRxB) ? b_q : a_q;
        for (int unsigned i = 0; i < NB; i++) begin
            if (cnt_q == CntW'(i)) slot_d[8*i +: 8] = bus_io.rx_data;
        end
    end

    assign cap = {bus_io.alu_flags, bus_io.alu_res};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= StRxA;
            cnt_q       <= '0;
            txcnt_q     <= '0;
            tmo_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            shreg_q     <= '0;
            cs_q        <= '0;
            cin_q       <= 1'b0;
            alu_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            en_rx_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            alu_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            err_q       <= 1'b0;

            if (rx_acc || !frame_open) begin
                tmo_q <= '0;
            end else if (TIMEOUT_CYC != 0) begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (tmo_hit) begin
                // Partial operand contents are kept; only the frame position restarts.
                err_q   <= 1'b1;
                cnt_q   <= '0;
                tmo_q   <= '0;
                state_q <= StRxA;
            end else begin
                case (state_q)
                    StRxA, StRxB: begin
                        if (rx_acc) begin
                            if (state_q == StRxA) a_q <= slot_d;
                            else                  b_q <= slot_d;
                            if (cnt_q == LastByte) begin
                                cnt_q   <= '0;
                                state_q <= (state_q == StRxA) ? StRxB : StRxOp;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    StRxOp: begin
                        if (rx_acc) begin
                            cs_q        <= bus_io.rx_data[2:0];
                            cin_q       <= bus_io.rx_data[3];
                            en_rx_q     <= 1'b0;
                            alu_start_q <= 1'b1;
                            state_q     <= StStart;
                        end
                    end
                    StStart: state_q <= StAluWait;
                    StAluWait: begin
                        if (bus_io.alu_done) begin
                            shreg_q    <= cap[DATA_W+7:8];
                            tx_data_q  <= bus_io.alu_res[7:0];
                            tx_start_q <= 1'b1;
                            txcnt_q    <= '0;
                            state_q    <= StTxByte;
                        end
                    end
                    StTxByte: state_q <= StTxWait;
                    StTxWait: begin
                        if (bus_io.tx_d_end) begin
                            if (txcnt_q == LastTx) begin
                                en_rx_q <= 1'b1;
                                state_q <= StRxA;
                            end else begin
                                // Next byte is issued straight away so tx_start trails
                                // tx_d_end by a single cycle.
                                txcnt_q    <= txcnt_q + 1'b1;
                                tx_data_q  <= shreg_q[7:0];
                                shreg_q    <= shreg_q >> 8;
                                tx_start_q <= 1'b1;
                                state_q    <= StTxByte;
                            end
                        end
                    end
                    default: state_q <= StRxA;
                endcase
            end
        end
    end

    assign bus_io.tx_start    = tx_start_q;
    assign bus_io.tx_data     = tx_data_q;
    assign bus_io.alu_data_a  = a_q;
    assign bus_io.alu_data_b  = b_q;
    assign bus_io.alu_cs      = cs_q;
    assign bus_io.alu_cin     = cin_q;
    assign bus_io.alu_start   = alu_start_q;
    assign bus_io.en_rx       = en_rx_q;
    assign bus_io.busy        = !((state_q == StRxA) && (cnt_q == '0));
    assign bus_io.err_timeout = err_q;
endmodule

// File: tb/tb_uart_alu_frame_ctl.sv
// Bench for uart_alu_frame_ctl: a 16-bit instance with a short timeout and an 8-bit instance
// with the timeout disabled, driven through a shared stimulus/observation mux.
module tb_uart_alu_frame_ctl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_alu_frame_ctl_if #(.DATA_W(16)) if16 ();
    uart_alu_frame_ctl_if #(.DATA_W(8))  if8 ();

    uart_alu_frame_ctl #(.DATA_W(16), .TIMEOUT_CYC(100)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus_io(if16)
    );
    uart_alu_frame_ctl #(.DATA_W(8), .TIMEOUT_CYC(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus_io(if8)
    );

    // sel = 0 targets the 16-bit instance, sel = 1 the 8-bit one.
    logic        sel;
    logic        drv_val, drv_tx_end, drv_done;
    logic [7:0]  drv_data, drv_flags;
    logic [15:0] drv_res;

    assign if16.rx_d_val  = drv_val & ~sel;
    assign if16.rx_data   = drv_data;
    assign if16.tx_d_end  = drv_tx_end & ~sel;
    assign if16.alu_done  = drv_done & ~sel;
    assign if16.alu_res   = drv_res;
    assign if16.alu_flags = drv_flags;
    assign if8.rx_d_val   = drv_val & sel;
    assign if8.rx_data    = drv_data;
    assign if8.tx_d_end   = drv_tx_end & sel;
    assign if8.alu_done   = drv_done & sel;
    assign if8.alu_res    = drv_res[7:0];
    assign if8.alu_flags  = drv_flags;

    logic        cur_tx_start, cur_cin, cur_alu_start, cur_en_rx, cur_busy, cur_err;
    logic [7:0]  cur_tx_data;
    logic [15:0] cur_a, cur_b;
    logic [2:0]  cur_cs;
    assign cur_tx_start  = sel ? if8.tx_start    : if16.tx_start;
    assign cur_tx_data   = sel ? if8.tx_data     : if16.tx_data;
    assign cur_a         = sel ? {8'h00, if8.alu_data_a} : if16.alu_data_a;
    assign cur_b         = sel ? {8'h00, if8.alu_data_b} : if16.alu_data_b;
    assign cur_cs        = sel ? if8.alu_cs      : if16.alu_cs;
    assign cur_cin       = sel ? if8.alu_cin     : if16.alu_cin;
    assign cur_alu_start = sel ? if8.alu_start   : if16.alu_start;
    assign cur_en_rx     = sel ? if8.en_rx       : if16.en_rx;
    assign cur_busy      = sel ? if8.busy        : if16.busy;
    assign cur_err       = sel ? if8.err_timeout : if16.err_timeout;

    int n_chk = 0;
    int n_fail = 0;
    int err_seen = 0;

    always @(posedge clk) if (cur_err === 1'b1) err_seen <= err_seen + 1;

    typedef struct {
        bit          dw8;
        logic [15:0] a, b;
        logic [7:0]  op;
        logic [15:0] res;
        logic [7:0]  flags;
        logic [2:0]  e_cs;
        logic        e_cin;
        logic [23:0] e_tx;   // transmitted bytes, first byte in [7:0]
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx_start"}, cur_tx_start, 0);
        chk({tag, "_tx_data"}, cur_tx_data, 0);
        chk({tag, "_a"}, cur_a, 0);
        chk({tag, "_b"}, cur_b, 0);
        chk({tag, "_cs"}, cur_cs, 0);
        chk({tag, "_cin"}, cur_cin, 0);
        chk({tag, "_alu_start"}, cur_alu_start, 0);
        chk({tag, "_en_rx"}, cur_en_rx, 1);
        chk({tag, "_busy"}, cur_busy, 0);
        chk({tag, "_err"}, cur_err, 0);
    endtask

    // Reference: result bytes LSB first, then flags; nb bytes per operand.
    function automatic logic [23:0] model_tx(input int nb, input logic [15:0] res,
                                             input logic [7:0] flags);
        int unsigned span = 1 << (8 * nb);
        return 24'((flags * span) + (res % span));
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        drv_val = 1'b1;
        drv_data = b;
        @(negedge clk);
        drv_val = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                             input logic [15:0] res, input logic [7:0] flags,
                             input logic [2:0] e_cs, input logic e_cin, input logic [23:0] e_tx,
                             input int gap, input bit junk, input bit early_done, input int dly);
        int nb, e0, t, nw;
        bit ok;
        logic [7:0]  hold;
        logic [15:0] tmp;
        logic [23:0] tb_bytes;
        nb = sel ? 1 : 2;
        e0 = err_seen;
        for (int i = 0; i < nb; i++) begin tmp = a >> (8 * i); send(tmp[7:0], gap); end
        for (int i = 0; i < nb; i++) begin tmp = b >> (8 * i); send(tmp[7:0], gap); end
        send(op, gap);
        chk("alu_start_after_op", cur_alu_start, 1);
        chk("en_rx_low", cur_en_rx, 0);
        chk("busy_in_start", cur_busy, 1);
        chk("op_a", cur_a, a);
        chk("op_b", cur_b, b);
        chk("op_cs", cur_cs, e_cs);
        chk("op_cin", cur_cin, e_cin);
        if (early_done) begin
            drv_done = 1'b1; drv_res = ~res; drv_flags = ~flags;
        end
        @(negedge clk);
        drv_done = 1'b0;
        chk("alu_start_one_cycle", cur_alu_start, 0);
        for (int i = 0; i < dly; i++) begin
            drv_val = junk && ($urandom_range(0, 1) == 1);
            drv_data = 8'($urandom);
            @(negedge clk);
        end
        drv_val = 1'b0;
        drv_done = 1'b1; drv_res = res; drv_flags = flags;
        @(negedge clk);
        drv_done = 1'b0; drv_res = 16'($urandom); drv_flags = 8'($urandom);
        for (int k = 0; k <= nb; k++) begin
            t = 0;
            while (cur_tx_start !== 1'b1 && t < 30) begin @(negedge clk); t++; end
            chk("tx_start_seen", cur_tx_start, 1);
            if (cur_tx_start !== 1'b1) return;
            if (k > 0) chk("tx_start_after_end", t, 0);
            tb_bytes = e_tx >> (8 * k);
            chk("tx_byte", cur_tx_data, tb_bytes[7:0]);
            hold = cur_tx_data;
            ok = 1'b1;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                drv_val = junk && ($urandom_range(0, 1) == 1);
                drv_data = 8'($urandom);
                @(negedge clk);
                if (cur_tx_start !== 1'b0 || cur_tx_data !== hold) ok = 1'b0;
            end
            drv_val = 1'b0;
            chk("tx_data_held", ok, 1);
            drv_tx_end = 1'b1;
            @(negedge clk);
            drv_tx_end = 1'b0;
        end
        chk("en_rx_restored", cur_en_rx, 1);
        chk("busy_idle", cur_busy, 0);
        chk("keep_a", cur_a, a);
        chk("keep_b", cur_b, b);
        chk("keep_cs", cur_cs, e_cs);
        chk("no_timeout", err_seen - e0, 0);
    endtask

    initial begin
        int t, bad, nb, e0;
        logic [15:0] ra, rb, rr;
        logic [7:0]  rop, rfl;

        vecs[0] = '{0, 16'h1234, 16'h5678, 8'h0B, 16'h68AC, 8'h01, 3'd3, 1'b1, 24'h0168AC};
        vecs[1] = '{0, 16'hFFFF, 16'h0001, 8'hF7, 16'h0000, 8'hC5, 3'd7, 1'b0, 24'hC50000};
        vecs[2] = '{0, 16'h0000, 16'h0000, 8'h08, 16'h8001, 8'h80, 3'd0, 1'b1, 24'h808001};
        vecs[3] = '{1, 16'h0005, 16'h0003, 8'h01, 16'h0008, 8'h00, 3'd1, 1'b0, 24'h000008};
        vecs[4] = '{1, 16'h00FF, 16'h0080, 8'h9E, 16'h007F, 8'hA5, 3'd6, 1'b1, 24'h00A57F};

        sel = 1'b0; rst_n = 1'b1;
        drv_val = 1'b0; drv_tx_end = 1'b0; drv_done = 1'b0;
        drv_data = '0; drv_res = '0; drv_flags = '0;
        repeat (3) @(negedge clk);
        chk_reset("rst_w16");
        sel = 1'b1; #1;
        chk_reset("rst_w8");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].dw8;
            run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flags,
                      vecs[i].e_cs, vecs[i].e_cin, vecs[i].e_tx, i % 2, i == 1, i == 2, 7);
        end

        for (int n = 0; n < 16; n++) begin
            sel = (n >= 12);
            nb = sel ? 1 : 2;
            ra = 16'($urandom); rb = 16'($urandom); rr = 16'($urandom);
            rop = 8'($urandom); rfl = 8'($urandom);
            if (sel) begin ra = ra % 256; rb = rb % 256; rr = rr % 256; end
            run_frame(ra, rb, rop, rr, rfl, 3'(rop % 8), 1'((rop / 8) % 2),
                      model_tx(nb, rr, rfl), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(1, 9));
        end

        // Partial frame abandoned after 100 idle cycles.
        sel = 1'b0;
        @(negedge clk);
        send(8'h11, 0);
        send(8'h22, 0);
        chk("busy_partial", cur_busy, 1);
        t = 0;
        while (cur_err !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        chk("timeout_latency", (t >= 100 && t <= 101), 1);
        @(negedge clk);
        chk("timeout_pulse_width", cur_err, 0);
        chk("timeout_busy_clear", cur_busy, 0);
        chk("timeout_keeps_a", cur_a, 16'h2211);
        run_frame(16'hBBAA, 16'hDDCC, 8'h02, 16'h1357, 8'h3C, 3'd2, 1'b0,
                  model_tx(2, 16'h1357, 8'h3C), 0, 0, 0, 3);

        // Long gaps on the instance whose timeout is disabled.
        sel = 1'b1;
        run_frame(16'h0005, 16'h0003, 8'h01, 16'h0008, 8'h00, 3'd1, 1'b0, 24'h000008,
                  150, 0, 0, 2);

        // Reset asserted while waiting on the first transmitted byte.
        sel = 1'b0;
        @(negedge clk);
        send(8'h11, 0); send(8'h11, 0); send(8'h22, 0); send(8'h22, 0); send(8'h05, 0);
        @(negedge clk);
        drv_done = 1'b1; drv_res = 16'hBEEF; drv_flags = 8'h42;
        @(negedge clk);
        drv_done = 1'b0;
        t = 0;
        while (cur_tx_start !== 1'b1 && t < 30) begin @(negedge clk); t++; end
        chk("rst_seq_tx0", cur_tx_data, 8'hEF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset("rst_mid_tx");
        @(negedge clk);
        rst_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            drv_tx_end = (i % 3 == 0);
            @(negedge clk);
            if (cur_tx_start !== 1'b0 || cur_alu_start !== 1'b0) bad++;
        end
        drv_tx_end = 1'b0;
        chk("no_stray_strobes_after_reset", bad, 0);
        e0 = err_seen;
        run_frame(16'hA5A5, 16'h5A5A, 8'h0C, 16'hFFFF, 8'h07, 3'd4, 1'b1,
                  model_tx(2, 16'hFFFF, 8'h07), 1, 1, 0, 4);
        chk("no_timeout_overall", err_seen - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_alu_frame_ctl.md
Name: uart_alu_frame_ctl

Overview:
Parametrised UART-to-ALU command sequencer. It assembles multi-byte operands, an opcode and a carry-in from the UART receiver. It starts the ALU with a start/done handshake, then serialises the result plus a flags byte back through the UART transmitter. It adds a partial-frame timeout and supports operand widths that are multiples of 8.

Parameters:
DATA_W, 8, operand/result width in bits; must be a multiple of 8, range 8..64.
TIMEOUT_CYC, 1000000, idle clocks allowed between received bytes mid-frame; 0 disables the timeout.
NB (localparam), DATA_W/8, bytes per operand.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  reset; asynchronous, active-high.
rx_d_val  input  1  one-cycle strobe: rx_data holds a valid byte.
rx_data  input  8  received byte.
tx_d_end  input  1  one-cycle strobe: transmitter finished the current byte.
tx_start  output  1  one-cycle strobe: send tx_data.
tx_data  output  8  byte to transmit; held stable from tx_start until tx_d_end.
alu_data_a  output  DATA_W  operand A.
alu_data_b  output  DATA_W  operand B.
alu_cs  output  3  ALU operation select.
alu_cin  output  1  ALU carry-in.
alu_start  output  1  one-cycle strobe: start the ALU.
alu_done  input  1  ALU result valid; level or pulse.
alu_res  input  DATA_W  ALU result.
alu_flags  input  8  ALU status flags.
en_rx  output  1  high while accepting bytes.
busy  output  1  high in every state except RX_A with byte count 0.
err_timeout  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset, asynchronous: state=RX_A; byte counter=0; timeout counter=0; alu_data_a=0; alu_data_b=0; alu_cs=0; alu_cin=0; alu_start=0; tx_start=0; tx_data=0; en_rx=1; busy=0; err_timeout=0. Reset mid-operation aborts immediately, with no stray tx_start or alu_start afterwards.
- Frame format: NB bytes of A (LSB first), NB bytes of B (LSB first), then one opcode byte. Opcode byte: bits[2:0] to alu_cs, bit[3] to alu_cin, bits[7:4] ignored.
- RX_A: on each rx_d_val, write rx_data into byte slot cnt of alu_data_a, then cnt++. After the NB-th byte: cnt=0, go to RX_B.
- RX_B: same loading into alu_data_b. After the NB-th byte go to RX_OP.
- RX_OP: on rx_d_val, load alu_cs and alu_cin, set en_rx=0, go to START.
- START: alu_start=1 for exactly one cycle, i.e. the cycle after the opcode byte is accepted. Go to ALU_WAIT.
- ALU_WAIT: alu_done is sampled only in this state; alu_done during START is ignored. On alu_done:
  - capture {alu_flags, alu_res} into the tx shift register;
  - txcnt=0;
  - go to TX_BYTE.
- TX_BYTE: tx_data = shift register byte txcnt; tx_start=1 for one cycle; go to TX_WAIT.
- TX_WAIT: tx_d_end is honoured only here. On tx_d_end:
  - txcnt++;
  - if txcnt < NB+1, go to TX_BYTE; the next tx_start follows tx_d_end by exactly 1 cycle;
  - otherwise set en_rx=1 and go to RX_A.
- Transmit order: result LSB..MSB, then the flags byte (NB+1 bytes total).
- rx_d_val while en_rx=0 is ignored; it is not buffered.
- Operand and opcode outputs hold their values from load until overwritten by the next frame.
- Timeout (TIMEOUT_CYC>0):
  - counter runs only in RX_A/RX_B/RX_OP when at least one byte of the current frame has been received;
  - counter clears on every accepted byte;
  - on reaching TIMEOUT_CYC: err_timeout pulses 1 cycle, cnt=0, state=RX_A;
  - operand registers keep their partial contents;
  - rx_d_val in the expiry cycle is dropped.
- No timeout applies in ALU_WAIT or TX_WAIT; waits there are unbounded.
- Throughput: one byte accepted per rx_d_val, including back-to-back (consecutive-cycle) strobes.

Test Plan:
- DATA_W=16: rx 0x34,0x12,0x78,0x56,0x0B -> alu_data_a=0x1234, alu_data_b=0x5678, alu_cs=3, alu_cin=1. alu_start high exactly 1 cycle, one cycle after the 5th byte; en_rx=0.
- Same frame, alu_done after 7 cycles with alu_res=0x68AC, alu_flags=0x01 -> tx_data 0xAC, 0x68, 0x01 on three tx_start pulses, each 1 cycle after the prior tx_d_end. en_rx=1 after the third tx_d_end.
- TIMEOUT_CYC=100, DATA_W=16: rx 0x11,0x22, then idle 100 cycles -> err_timeout pulse. A following frame 0xAA,0xBB,... loads alu_data_a=0xBBAA.
- rx_d_val pulses during ALU_WAIT and TX_WAIT -> no operand change, no state change; the transmitted bytes are unchanged.
- Assert rst_n during TX_WAIT after the first byte -> all outputs at reset values, no further tx_start. A new frame then completes normally.
- DATA_W=8: rx 0x05,0x03,0x01 -> a=0x05, b=0x03, cs=1, cin=0. alu_res=0x08, flags=0x00 -> tx 0x08, 0x00.
